// File: rtl/ps2_kbd_matrix_pkg.sv
// ps2_kbd_matrix_pkg: shared constants, receiver states and key-target record for the PS/2 keyboard front end.
package ps2_kbd_matrix_pkg;

    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_E1 = 8'hE1;
    localparam logic [7:0] PS2_AA = 8'hAA;

    localparam int ZX_ROWS = 8;
    localparam int ZX_COLS = 5;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
        logic       valid2;
        logic [2:0] row2;
        logic [2:0] col2;
        logic       joy_valid;
        logic [2:0] joy_bit;
    } key_target_t;

    function automatic key_target_t zx_key(input logic [2:0] row, input logic [2:0] col);
        key_target_t t;
        t       = '0;
        t.valid = 1'b1;
        t.row   = row;
        t.col   = col;
        return t;
    endfunction

    function automatic key_target_t joy_key(input logic [2:0] b);
        key_target_t t;
        t           = '0;
        t.joy_valid = 1'b1;
        t.joy_bit   = b;
        return t;
    endfunction

endpackage

// File: rtl/ps2_kbd_matrix_map.sv
// ps2_scancode_map: combinational lookup from {ext, set-2 code} to ZX matrix / joystick targets.
module ps2_scancode_map
    import ps2_kbd_matrix_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  code,
    output key_target_t target
);

    always_comb begin
        target = '0;
        case ({ext, code})
            9'h012, 9'h059: target = zx_key(3'd0, 3'd0);
            9'h01A: target = zx_key(3'd0, 3'd1);
            9'h022: target = zx_key(3'd0, 3'd2);
            9'h021: target = zx_key(3'd0, 3'd3);
            9'h02A: target = zx_key(3'd0, 3'd4);
            9'h01C: target = zx_key(3'd1, 3'd0);
            9'h01B: target = zx_key(3'd1, 3'd1);
            9'h023: target = zx_key(3'd1, 3'd2);
            9'h02B: target = zx_key(3'd1, 3'd3);
            9'h034: target = zx_key(3'd1, 3'd4);
            9'h015: target = zx_key(3'd2, 3'd0);
            9'h01D: target = zx_key(3'd2, 3'd1);
            9'h024: target = zx_key(3'd2, 3'd2);
            9'h02D: target = zx_key(3'd2, 3'd3);
            9'h02C: target = zx_key(3'd2, 3'd4);
            9'h016: target = zx_key(3'd3, 3'd0);
            9'h01E: target = zx_key(3'd3, 3'd1);
            9'h026: target = zx_key(3'd3, 3'd2);
            9'h025: target = zx_key(3'd3, 3'd3);
            9'h02E: target = zx_key(3'd3, 3'd4);
            9'h045: target = zx_key(3'd4, 3'd0);
            9'h046: target = zx_key(3'd4, 3'd1);
            9'h03E: target = zx_key(3'd4, 3'd2);
            9'h03D: target = zx_key(3'd4, 3'd3);
            9'h036: target = zx_key(3'd4, 3'd4);
            9'h04D: target = zx_key(3'd5, 3'd0);
            9'h044: target = zx_key(3'd5, 3'd1);
            9'h043: target = zx_key(3'd5, 3'd2);
            9'h03C: target = zx_key(3'd5, 3'd3);
            9'h035: target = zx_key(3'd5, 3'd4);
            9'h05A: target = zx_key(3'd6, 3'd0);
            9'h04B: target = zx_key(3'd6, 3'd1);
            9'h042: target = zx_key(3'd6, 3'd2);
            9'h03B: target = zx_key(3'd6, 3'd3);
            9'h033: target = zx_key(3'd6, 3'd4);
            9'h029: target = zx_key(3'd7, 3'd0);
            9'h014: target = zx_key(3'd7, 3'd1);
            9'h03A: target = zx_key(3'd7, 3'd2);
            9'h031: target = zx_key(3'd7, 3'd3);
            9'h032: target = zx_key(3'd7, 3'd4);
            // Backspace is Caps Shift + 0
            9'h066: begin
                target        = zx_key(3'd0, 3'd0);
                target.valid2 = 1'b1;
                target.row2   = 3'd4;
                target.col2   = 3'd0;
            end
            9'h174: target = joy_key(3'd0);
            9'h16B: target = joy_key(3'd1);
            9'h172: target = joy_key(3'd2);
            9'h175: target = joy_key(3'd3);
            9'h114: target = joy_key(3'd4);
            default: target = '0;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_matrix.sv
// ps2_kbd_matrix: PS/2 receiver and set-2 decoder feeding a ZX 8x5 key matrix, cursor joystick,
// magic button and Ctrl+Alt+Del reset request; kd answers half-row selects one clk28 later.
module ps2_kbd_matrix
    import ps2_kbd_matrix_pkg::*;
#(
    parameter int FILTER_LEN = 16,
    parameter int TIMEOUT    = 4095
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic [7:0] kempston_data,
    output logic       magic_button,
    output logic       reset_req
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync, dat_sync, raw, filt;
    logic          fclk_q, fall, fdat;
    rx_state_t     state, state_nx;
    logic [TW-1:0] tmo;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt, skip;
    logic          par, byte_valid;
    logic          rel, ext, lctrl, alt, del, combo_q;
    logic [ZX_ROWS-1:0][ZX_COLS-1:0] matrix;
    logic [ZX_COLS-1:0] sel;
    key_target_t   tgt;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            fclk_q   <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            fclk_q   <= filt[0];
        end
    end

    assign raw = {dat_sync[1], clk_sync[1]};

    // a filtered level flips only after FILTER_LEN consecutive samples of the new level
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic          f;
        logic [FW-1:0] c;
        always_ff @(posedge clk28 or negedge rst_n) begin
            if (!rst_n) begin
                f <= 1'b1;
                c <= '0;
            end else if (raw[i] == f) begin
                c <= '0;
            end else if (c == FW'(FILTER_LEN - 1)) begin
                f <= raw[i];
                c <= '0;
            end else begin
                c <= c + 1'b1;
            end
        end
        assign filt[i] = f;
    end

    assign fall = fclk_q & ~filt[0];
    assign fdat = filt[1];

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (fall) begin
            case (state)
                IDLE:    state_nx = fdat ? IDLE : DATA;
                DATA:    state_nx = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_nx = STOP;
                default: state_nx = IDLE;
            endcase
        end else if (tmo == '0 && state != IDLE) begin
            state_nx = IDLE;
        end
    end

    always_comb byte_valid = (state == STOP) && fall && fdat && ^{par, shift};

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            tmo     <= TW'(TIMEOUT);
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            tmo <= fall ? TW'(TIMEOUT) : tmo - TW'(tmo != '0);
            if (state == IDLE) bit_cnt <= '0;
            if (fall && state == DATA) begin
                shift   <= {fdat, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state == PARITY) par <= fdat;
        end
    end

    ps2_scancode_map u_map (
        .ext    (ext),
        .code   (shift),
        .target (tgt)
    );

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            matrix        <= '0;
            kempston_data <= '0;
            magic_button  <= 1'b0;
            rel           <= 1'b0;
            ext           <= 1'b0;
            skip          <= '0;
            lctrl         <= 1'b0;
            alt           <= 1'b0;
            del           <= 1'b0;
        end else if (byte_valid) begin
            if (skip != '0) begin
                skip <= skip - 3'd1;
            end else if (shift == PS2_F0) begin
                rel <= 1'b1;
            end else if (shift == PS2_E0) begin
                ext <= 1'b1;
            end else if (shift == PS2_E1) begin
                skip <= 3'd7;
            end else if (shift == 8'h00 || shift == 8'hFF) begin
                matrix        <= '0;
                kempston_data <= '0;
                magic_button  <= 1'b0;
                rel           <= 1'b0;
                ext           <= 1'b0;
            end else if (shift != PS2_AA) begin
                if (tgt.valid)     matrix[tgt.row][tgt.col]   <= ~rel;
                if (tgt.valid2)    matrix[tgt.row2][tgt.col2] <= ~rel;
                if (tgt.joy_valid) kempston_data[tgt.joy_bit] <= ~rel;
                if (!ext && shift == 8'h07) magic_button <= ~rel;
                if (!ext && shift == 8'h14) lctrl <= ~rel;
                if (shift == 8'h11)         alt   <= ~rel;
                if (ext && shift == 8'h71)  del   <= ~rel;
                rel <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    // pulse on the rising edge of the three-key combination
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            combo_q   <= 1'b0;
            reset_req <= 1'b0;
        end else begin
            combo_q   <= lctrl & alt & del;
            reset_req <= lctrl & alt & del & ~combo_q;
        end
    end

    always_comb begin
        sel = '0;
        for (int r = 0; r < ZX_ROWS; r++) sel = sel | ({ZX_COLS{~addr_hi[r]}} & matrix[r]);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) kd <= 5'h1F;
        else        kd <= ~sel;
    end

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// tb_ps2_kbd_matrix: directed PS/2 frames against a scancode-table model of the ZX keyboard,
// checked every settled cycle plus hand-computed literal expectations.
module tb_ps2_kbd_matrix;

    localparam int TIMEOUT = 4095;
    localparam int HALF    = 30;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] addr_hi = 8'hFF;
    logic [4:0] kd;
    logic [7:0] kempston_data;
    logic       magic_button;
    logic       reset_req;

    int   passed = 0;
    int   total = 0;
    int   rr_count = 0;
    bit   settled = 0;
    logic [7:0] addr_seen = 8'hFF;

    ps2_kbd_matrix #(.FILTER_LEN(16), .TIMEOUT(TIMEOUT)) dut (
        .clk28         (clk28),
        .rst_n         (rst_n),
        .ps2_clk       (ps2_clk),
        .ps2_dat       (ps2_dat),
        .addr_hi       (addr_hi),
        .kd            (kd),
        .kempston_data (kempston_data),
        .magic_button  (magic_button),
        .reset_req     (reset_req)
    );

    always #18 clk28 = ~clk28;

    // model: ZX keys as a flat row*5+col array, found by scancode search
    logic [7:0] zx_tbl [40] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h14, 8'h3A, 8'h31, 8'h32};
    logic [7:0] joy_tbl [5] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14};
    bit       m_key [40];
    bit [7:0] m_joy = '0;
    bit       m_magic = 0, m_rel = 0, m_ext = 0;
    int       m_skip = 0;

    task model_byte(input logic [7:0] b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hF0) m_rel = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hAA) ;
        else if (b == 8'h00 || b == 8'hFF) begin
            for (int i = 0; i < 40; i++) m_key[i] = 0;
            m_joy = '0; m_magic = 0; m_rel = 0; m_ext = 0;
        end else begin
            if (!m_ext) begin
                for (int i = 0; i < 40; i++) if (zx_tbl[i] == b) m_key[i] = !m_rel;
                if (b == 8'h59) m_key[0] = !m_rel;
                if (b == 8'h66) begin m_key[0] = !m_rel; m_key[20] = !m_rel; end
                if (b == 8'h07) m_magic = !m_rel;
            end else begin
                for (int i = 0; i < 5; i++) if (joy_tbl[i] == b) m_joy[i] = !m_rel;
            end
            m_rel = 0; m_ext = 0;
        end
    endtask

    function automatic logic [4:0] model_kd(input logic [7:0] a);
        logic [4:0] k;
        k = 5'h1F;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!a[r] && m_key[r*5+c]) k[c] = 1'b0;
        return k;
    endfunction

    task check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk28) addr_seen <= addr_hi;
    always @(negedge clk28) if (reset_req) rr_count++;

    always @(negedge clk28) begin
        if (settled) begin
            total++;
            if (kd === model_kd(addr_seen) && kempston_data === {3'b000, m_joy[4:0]} && magic_button === m_magic)
                passed++;
            else
                $display("FAIL cycle: kd=%b kemp=%h magic=%b expected kd=%b kemp=%h magic=%b addr=%h at %0t",
                         kd, kempston_data, magic_button, model_kd(addr_seen), {3'b000, m_joy[4:0]}, m_magic, addr_seen, $time);
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0, input int edges = 11);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        settled = 0;
        for (int i = 0; i < edges; i++) begin
            ps2_dat = f[i];
            repeat (HALF) @(posedge clk28);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk28);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(posedge clk28);
        if (edges == 11 && !bad_par && !bad_stop) model_byte(b);
        settled = 1;
    endtask

    task set_addr(input logic [7:0] a);
        @(posedge clk28);
        #1 addr_hi = a;
    endtask

    task lit_kd(input string name, input logic [7:0] a, input logic [4:0] exp);
        set_addr(a);
        repeat (2) @(negedge clk28);
        check(name, {3'b000, kd}, {3'b000, exp});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge clk28);
        @(negedge clk28);
        check("reset kd", {3'b000, kd}, 8'h1F);
        check("reset kempston", kempston_data, 8'h00);
        check("reset magic", {7'd0, magic_button}, 8'h00);
        check("reset reset_req", {7'd0, reset_req}, 8'h00);
        @(posedge clk28);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk28);
        settled = 1;

        // single key press and release
        send_frame(8'h1C);
        lit_kd("t1 A at FD", 8'hFD, 5'b11110);
        lit_kd("t1 FF", 8'hFF, 5'b11111);
        set_addr(8'hFE);
        send_frame(8'hF0);
        send_frame(8'h1C);
        lit_kd("t2 A released", 8'hFD, 5'b11111);

        // corrupt frames are dropped
        send_frame(8'h1C, 1, 0);
        lit_kd("t3 bad parity", 8'hFD, 5'b11111);
        send_frame(8'h1C, 0, 1);
        lit_kd("t3 bad stop", 8'hFD, 5'b11111);

        // joystick
        send_frame(8'hE0); send_frame(8'h75);
        check("t4 up", kempston_data, 8'h08);
        send_frame(8'hE0); send_frame(8'h14);
        check("t4 up+fire", kempston_data, 8'h18);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        check("t4 fire only", kempston_data, 8'h10);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h14);
        lit_kd("t4 matrix untouched", 8'h00, 5'b11111);

        // backspace composite
        send_frame(8'h66);
        lit_kd("t5 bksp EE", 8'hEE, 5'b11110);
        lit_kd("t5 bksp FE", 8'hFE, 5'b11110);
        lit_kd("t5 bksp EF", 8'hEF, 5'b11110);
        send_frame(8'hF0); send_frame(8'h66);
        lit_kd("t5 bksp released", 8'hEE, 5'b11111);

        // partial frame abandoned by timeout
        send_frame(8'h16, 0, 0, 5);
        repeat (TIMEOUT + 10) @(posedge clk28);
        send_frame(8'h16);
        lit_kd("t6 key 1 after timeout", 8'hF7, 5'b11110);
        send_frame(8'hF0); send_frame(8'h16);

        // Ctrl+Alt+Del
        send_frame(8'h14);
        send_frame(8'h11);
        check("cad before del", rr_count[7:0], 8'd0);
        send_frame(8'hE0); send_frame(8'h71);
        check("cad pulse once", rr_count[7:0], 8'd1);
        lit_kd("cad SS held", 8'h7F, 5'b11101);
        send_frame(8'hF0); send_frame(8'h14);
        send_frame(8'hF0); send_frame(8'h11);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h71);
        check("cad after release", rr_count[7:0], 8'd1);

        // magic button
        send_frame(8'h07);
        check("f12 press", {7'd0, magic_button}, 8'h01);
        send_frame(8'hF0); send_frame(8'h07);
        check("f12 release", {7'd0, magic_button}, 8'h00);

        // Pause sequence is swallowed whole
        send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77); send_frame(8'hE1);
        send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h77);
        lit_kd("pause no SS", 8'h7F, 5'b11111);
        send_frame(8'h1C);
        lit_kd("after pause A", 8'hFD, 5'b11110);

        // overrun clears everything
        send_frame(8'h07);
        send_frame(8'hE0); send_frame(8'h75);
        send_frame(8'h00);
        lit_kd("overrun kd", 8'h00, 5'b11111);
        check("overrun kempston", kempston_data, 8'h00);
        check("overrun magic", {7'd0, magic_button}, 8'h00);

        settled = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
